// File: rtl/snes_pad_reader.sv
// snes_pad_reader
//   Free-running SNES pad poller. Once per poll period it pulses the pad
//   latch, clocks out the pad's 16-bit serial report and presents the 12
//   button bits (1 = pressed) to the CPU's control FSM.
//
//   Optional feature macro: SNES_DETECT_EN
//     defined   - a report whose ID bits [15:12] are all zero is treated as
//                 "no pad": present drops and snes_data reports no buttons.
//     undefined - present is 1 outside reset; a stuck-low line reads 12'hFFF.
//
// Parameters
//   HALF_CYCLES  clk cycles per pad half-period (>= 4)
//   POLL_CYCLES  clk cycles from one frame start to the next (> 34*HALF_CYCLES)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   snes_serial  pad data line, asynchronous, active-low (0 = pressed)
//   snes_latch   pad latch, active-high
//   snes_clk     pad clock, idles high
//   snes_data    button state, 1 = pressed: [0]B [1]Y [2]Select [3]Start
//                [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R
//   data_valid   one-cycle pulse when snes_data updates
//   busy         high while a frame (latch + shift) is in progress
//   present      pad detected
module snes_pad_reader #(
    parameter int HALF_CYCLES = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snes_serial,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] snes_data,
    output logic        data_valid,
    output logic        busy,
    output logic        present
);

    localparam int PHASE_W = $clog2(2 * HALF_CYCLES);
    localparam int POLL_W  = $clog2(POLL_CYCLES);

    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         bit_q, bit_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic [15:0]        raw_q, raw_d;
    logic               serial_meta_q, serial_meta_d;
    logic               serial_sync_q, serial_sync_d;
    logic               latch_q, latch_d;
    logic               sclk_q, sclk_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               present_q, present_d;
    logic [11:0]        data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            bit_q         <= '0;
            // Loaded as expired so the first frame starts right after reset.
            poll_q        <= POLL_LAST;
            raw_q         <= '0;
            serial_meta_q <= 1'b1;
            serial_sync_q <= 1'b1;
            latch_q       <= 1'b0;
            sclk_q        <= 1'b1;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            present_q     <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_q         <= bit_d;
            poll_q        <= poll_d;
            raw_q         <= raw_d;
            serial_meta_q <= serial_meta_d;
            serial_sync_q <= serial_sync_d;
            latch_q       <= latch_d;
            sclk_q        <= sclk_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            present_q     <= present_d;
            data_q        <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        bit_d         = bit_q;
        raw_d         = raw_q;
        data_d        = data_q;
        present_d     = present_q;
        serial_meta_d = snes_serial;
        serial_sync_d = serial_meta_q;

        // The poll counter free-runs so frame start-to-start is exactly
        // POLL_CYCLES regardless of how long the frame itself takes.
        poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + POLL_W'(1);

        case (state_q)
            IDLE: begin
                if (poll_q == POLL_LAST) begin
                    state_d = LATCH;
                    phase_d = '0;
                    bit_d   = '0;
                    raw_d   = '0;
                end
            end
            LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = CLK_LO;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            CLK_LO: begin
                // Sample at the very end of the low phase: the pad shifted
                // on the previous rising edge, so the line has long settled.
                if (phase_q == HALF_LAST) begin
                    raw_d[bit_q] = serial_sync_q;
                    state_d      = CLK_HI;
                    phase_d      = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            CLK_HI: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = DONE;
                        // Data is loaded on entry to DONE so it appears in
                        // the same cycle as the valid pulse.
`ifdef SNES_DETECT_EN
                        if (raw_q[15:12] == 4'b0000) begin
                            present_d = 1'b0;
                            data_d    = 12'h000;
                        end else begin
                            present_d = 1'b1;
                            data_d    = ~raw_q[11:0];
                        end
`else
                        data_d = ~raw_q[11:0];
`endif
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = CLK_LO;
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifndef SNES_DETECT_EN
        present_d = 1'b1;
`endif

        // Pad-facing outputs are decoded from the next state and registered,
        // so they change only on clock edges and cannot glitch.
        latch_d = (state_d == LATCH);
        sclk_d  = (state_d != CLK_LO);
        busy_d  = (state_d == LATCH) || (state_d == CLK_LO) || (state_d == CLK_HI);
        valid_d = (state_d == DONE);
    end

    assign snes_latch = latch_q;
    assign snes_clk   = sclk_q;
    assign snes_data  = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign present    = present_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader
//   Bench for snes_pad_reader with HALF_CYCLES=4, POLL_CYCLES=200 and a
//   behavioural pad that reloads on latch and shifts on rising snes_clk.
//   Expected button words are queued when a pad pattern is applied and
//   compared when data_valid pulses. Honours SNES_DETECT_EN.
module tb_snes_pad_reader;

    localparam int HALF = 4;
    localparam int POLL = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snes_serial;
    logic        snes_latch;
    logic        snes_clk;
    logic [11:0] snes_data;
    logic        data_valid;
    logic        busy;
    logic        present;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] data;
        logic        present;
    } exp_t;

    typedef struct {
        logic [11:0] pattern;
        logic        connected;
        logic [11:0] exp_data;
        logic        exp_present;
    } vec_t;

    exp_t sb_q[$];

    // Pad model
    logic [15:0] pad_word = 16'hFFFF;
    logic        pad_connected = 1'b1;
    int          pad_idx = 0;

    snes_pad_reader #(
        .HALF_CYCLES(HALF),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .snes_serial(snes_serial),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_data  (snes_data),
        .data_valid (data_valid),
        .busy       (busy),
        .present    (present)
    );

    always #5 clk = ~clk;

    always @(posedge snes_clk or posedge snes_latch) begin
        if (snes_latch) pad_idx <= 0;
        else            pad_idx <= pad_idx + 1;
    end

    always_comb begin
        if (!pad_connected)  snes_serial = 1'b0;
        else if (pad_idx < 16) snes_serial = pad_word[pad_idx[3:0]];
        else                 snes_serial = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] pattern, input logic connected,
                                 input logic [11:0] exp_data, input logic exp_present);
        exp_t e;
        pad_word      = {4'hF, ~pattern};
        pad_connected = connected;
        e.data        = exp_data;
        e.present     = exp_present;
        sb_q.push_back(e);
    endtask

    // Scoreboard and protocol monitors
    int   valid_count = 0;
    int   overlap_err = 0;
    logic prev_valid = 1'b0;
    logic [11:0] prev_data = '0;
    logic reset_seen = 1'b1;

    always @(posedge clk) reset_seen <= reset;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_seen) begin
            if (data_valid) begin
                valid_count++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_data", {20'd0, snes_data}, {20'd0, e.data});
                    checkOutput("sb_present", {31'd0, present}, {31'd0, e.present});
                end
                if (prev_valid) checkOutput("valid_pulse_width", 32'd2, 32'd1);
            end
            if (snes_data != prev_data)
                checkOutput("data_change_without_valid", {31'd0, data_valid}, 32'd1);
            if (snes_latch && !snes_clk) overlap_err++;
        end
        prev_valid = data_valid;
        prev_data  = snes_data;
    end

    task automatic waitValid(input string name);
        int start;
        int n;
        start = valid_count;
        n = 0;
        while (valid_count == start && n < 3 * POLL) begin
            @(negedge clk);
            n++;
        end
        if (valid_count == start) checkOutput(name, 32'd0, 32'd1);
    endtask

    task automatic waitFrameStart(input string name);
        int n;
        n = 0;
        while (!busy && n < 3 * POLL) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        logic stuck_present;
        logic [11:0] stuck_data;
        int lat_cnt, low_cnt, falls;
        logic prev_c;

`ifdef SNES_DETECT_EN
        stuck_present = 1'b0;
        stuck_data    = 12'h000;
`else
        stuck_present = 1'b1;
        stuck_data    = 12'hFFF;
`endif
        vecs[0] = '{12'h801, 1'b1, 12'h801, 1'b1};
        vecs[1] = '{12'h000, 1'b1, 12'h000, 1'b1};
        vecs[2] = '{12'h110, 1'b1, 12'h110, 1'b1};
        vecs[3] = '{12'h555, 1'b1, 12'h555, 1'b1};
        vecs[4] = '{12'hAAA, 1'b1, 12'hAAA, 1'b1};
        vecs[5] = '{12'hFFF, 1'b1, 12'hFFF, 1'b1};
        vecs[6] = '{12'h000, 1'b0, stuck_data, stuck_present};
        vecs[7] = '{12'h123, 1'b1, 12'h123, 1'b1};

        // Reset release and frame timing, B+R pressed
        applyStimulus(12'h801, 1'b1, 12'h801, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_latch", {31'd0, snes_latch}, 32'd0);
        checkOutput("rst_clk", {31'd0, snes_clk}, 32'd1);
        checkOutput("rst_data", {20'd0, snes_data}, 32'd0);
        checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_present", {31'd0, present}, 32'd0);

        lat_cnt = 0; low_cnt = 0; falls = 0; prev_c = 1'b1;
        for (int c = 1; c <= 137; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("t1_latch_rise", {31'd0, snes_latch}, 32'd1);
            if (c == 9) begin
                checkOutput("t1_latch_fall", {31'd0, snes_latch}, 32'd0);
                checkOutput("t1_clk_first_low", {31'd0, snes_clk}, 32'd0);
            end
            if (c == 13) checkOutput("t1_clk_first_high", {31'd0, snes_clk}, 32'd1);
            if (c == 136) begin
                checkOutput("t1_busy_last", {31'd0, busy}, 32'd1);
                checkOutput("t1_no_early_valid", {31'd0, data_valid}, 32'd0);
            end
            if (c == 137) begin
                checkOutput("t1_valid_at_137", {31'd0, data_valid}, 32'd1);
                checkOutput("t1_busy_done", {31'd0, busy}, 32'd0);
            end
            lat_cnt += int'(snes_latch);
            low_cnt += int'(!snes_clk);
            if (prev_c && !snes_clk) falls++;
            prev_c = snes_clk;
        end
        checkOutput("t1_latch_cycles", lat_cnt, 2 * HALF);
        checkOutput("t1_clk_low_cycles", low_cnt, 16 * HALF);
        checkOutput("t1_clk_periods", falls, 16);

        applyStimulus(12'h801, 1'b1, 12'h801, 1'b1);
        for (int c = 138; c <= 201; c++) begin
            @(negedge clk);
            if (c == 200) checkOutput("t1_idle_before_poll", {31'd0, snes_latch}, 32'd0);
            if (c == 201) checkOutput("t1_second_latch", {31'd0, snes_latch}, 32'd1);
        end
        waitValid("t2_frame2_valid_timeout");

        // Table-driven patterns, including stuck-low line and reconnect
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pattern, vecs[i].connected,
                          vecs[i].exp_data, vecs[i].exp_present);
            waitValid("vec_valid_timeout");
        end

        // New pattern must not show until its own valid pulse
        applyStimulus(12'h3C5, 1'b1, 12'h3C5, 1'b1);
        waitFrameStart("t5_frame_start");
        checkOutput("t5_hold_old", {20'd0, snes_data}, 32'h123);
        waitValid("t5_valid_timeout");

        // Reset mid-shift aborts the frame
        applyStimulus(12'h0F0, 1'b1, 12'h0F0, 1'b1);
        waitFrameStart("t4_frame_start");
        repeat (58) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t4_latch", {31'd0, snes_latch}, 32'd0);
        checkOutput("t4_clk", {31'd0, snes_clk}, 32'd1);
        checkOutput("t4_data", {20'd0, snes_data}, 32'd0);
        checkOutput("t4_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("t4_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        reset = 1'b0;
        applyStimulus(12'h0F0, 1'b1, 12'h0F0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t4_fresh_latch", {31'd0, snes_latch}, 32'd1);
        waitValid("t4_valid_timeout");

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", sb_q.size(), 0);
        checkOutput("latch_clk_overlap", overlap_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
